// File: rtl/mod6_pkg.sv
// Shared constants and T-input equations for the modulo-6 counter.
// Latency: none (package only).
// Backpressure: none (package only).
package mod6_pkg;

  localparam int MOD6_MODULUS = 6;
  localparam int MOD6_MAX     = 5;
  localparam int MOD6_Q_W     = 4;
  localparam int MOD6_STATE_W = 3;

  // Toggle enables for the three state flops, derived from the current state
  // so that 0..5 step by one, 5 wraps to 0, and 6/7 fall back to 0.
  //   t0 = 1 except in state 6 (110 -> 000 needs bit 0 to hold)
  //   t1 = 1 in states 1,3 (carry into bit 1) and 6,7 (clear bit 1)
  //   t2 = majority(q2,q1,q0): states 3,5,6,7
  function automatic logic [MOD6_STATE_W-1:0] mod6_t_inputs(
    input logic [MOD6_STATE_W-1:0] s
  );
    logic [MOD6_STATE_W-1:0] t;
    t    = '0;
    t[0] = ~s[2] | ~s[1] | s[0];
    t[1] = (~s[2] & s[0]) | (s[2] & s[1]);
    t[2] = (s[1] & s[0]) | (s[2] & s[0]) | (s[2] & s[1]);
    return t;
  endfunction

endpackage

// File: rtl/modulus_6_counter_t_ff.sv
// T flip-flop: toggles on rising clk when t=1, holds otherwise.
// Latency: one clk-to-q after the rising edge.
// Backpressure: none; always accepts t.
// Ports: clk (clock), rst (async active-low clear), t (toggle enable), q (state).
module t_ff (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/modulus_6_counter.sv
// Free-running synchronous modulo-6 counter built from three T flip-flops.
// Latency: q updates one clk-to-q after every rising edge; tc is combinational from q.
// Backpressure: none; the counter is always enabled.
// Ports: clk (only clock), rst (async active-low reset), q[3:0] count 0..5 (q[3]=0),
//        tc (high while count is 5; present only when MOD6_TC_OUT_EN is defined).
module modulus_6_counter
  import mod6_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  output logic [MOD6_Q_W-1:0] q
`ifdef MOD6_TC_OUT_EN
  ,
  output logic                tc
`endif
);

  logic [MOD6_STATE_W-1:0] state;
  logic [MOD6_STATE_W-1:0] t;

  // All flops share clk; toggles come only from the present state.
  assign t = mod6_t_inputs(state);

  t_ff u_tff0 (
    .clk (clk),
    .rst (rst),
    .t   (t[0]),
    .q   (state[0])
  );

  t_ff u_tff1 (
    .clk (clk),
    .rst (rst),
    .t   (t[1]),
    .q   (state[1])
  );

  t_ff u_tff2 (
    .clk (clk),
    .rst (rst),
    .t   (t[2]),
    .q   (state[2])
  );

  // Upper bit(s) of the bus are never used by a count of 0..5.
  assign q = {{(MOD6_Q_W - MOD6_STATE_W){1'b0}}, state};

`ifdef MOD6_TC_OUT_EN
  // Reset clears the state, so tc is naturally low during reset.
  assign tc = (state == MOD6_STATE_W'(MOD6_MAX));
`endif

endmodule

// File: tb/tb_modulus_6_counter.sv
// Scoreboard bench: a count-level model pushes the expected value after every
// rising edge; a monitor pops and compares on every falling edge.
module tb_modulus_6_counter;
  import mod6_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] q;
`ifdef MOD6_TC_OUT_EN
  logic       tc;
`endif

  modulus_6_counter dut (
    .clk (clk),
    .rst (rst),
    .q   (q)
`ifdef MOD6_TC_OUT_EN
    ,
    .tc  (tc)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int model  = 0;
  int exp_q[$];
  int mon_exp;
  logic [2:0] inj;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: count value in plain arithmetic. Anything at or beyond
  // the last legal count (including corrupted values) returns to 0.
  always @(posedge clk) begin
    if (!rst)                          model = 0;
    else if (model >= MOD6_MODULUS - 1) model = 0;
    else                               model = model + 1;
    exp_q.push_back(model);
  end

  always @(negedge rst) model = 0;

  // Monitor: invariants every cycle plus the scoreboard comparison.
  initial begin
    forever begin
      @(negedge clk);
      check("q_bit3_zero", int'(q[3]), 0);
      check("q_le_max", int'(q <= 4'd5), 1);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("q_seq", int'(q), mon_exp);
`ifdef MOD6_TC_OUT_EN
        check("tc", int'(tc), int'(mon_exp == 5));
`endif
      end
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drop reset between edges once the count reaches tgt.
  task automatic mid_reset(input int tgt, input int hold);
    int waited;
    waited = 0;
    while (model != tgt && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    if (model != tgt) begin
      check("mid_reset_reach", model, tgt);
    end else begin
      #2 rst = 1'b0;
      #1 check("async_reset_q", int'(q), 0);
`ifdef MOD6_TC_OUT_EN
      check("async_reset_tc", int'(tc), 0);
`endif
      repeat (hold) @(negedge clk);
      #2 rst = 1'b1;
    end
  endtask

  // Corrupt the state to an illegal value between edges.
  task automatic inject(input int val);
    @(negedge clk);
    #1;
    inj = 3'(val);
    force dut.u_tff0.q = inj[0];
    force dut.u_tff1.q = inj[1];
    force dut.u_tff2.q = inj[2];
    model = val;
    #1;
    release dut.u_tff0.q;
    release dut.u_tff1.q;
    release dut.u_tff2.q;
    #1 check("inject_taken", int'(q), val);
  endtask

  initial begin
    int action;
    rst = 1'b0;
    inj = 3'd0;
    run_cycles(2);          // reset hold across two rising edges
    #2 rst = 1'b1;
    run_cycles(20);         // free run: 1,2,3,4,5,0,...
    mid_reset(3, 1);
    run_cycles(4);
    inject(6);
    run_cycles(7);
    inject(7);
    run_cycles(7);
    for (int it = 0; it < 10; it++) begin
      action = int'($urandom_range(0, 2));
      case (action)
        0:       run_cycles(int'($urandom_range(1, 15)));
        1:       mid_reset(int'($urandom_range(0, 5)), int'($urandom_range(1, 3)));
        default: inject(int'($urandom_range(6, 7)));
      endcase
      run_cycles(int'($urandom_range(2, 8)));
    end
    run_cycles(3);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/modulus_6_counter.md
# modulus_6_counter

Synchronous modulo-6 up-counter built structurally from three T flip-flops sharing one clock. It steps 0,1,2,3,4,5 and wraps to 0, presenting the count on a 4-bit bus. It is a free-running divide-by-6 / sequence source for downstream control logic.

## Interface
- Parameters: none. Modulus and widths are fixed and come from the shared package.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- q  output  4  current count, 0..5; q[3] is always 0.
- tc  output  1  terminal count; present only when MOD6_TC_OUT_EN is defined.

## Operation
- State: three T flip-flops hold q[2:0]. q[3] is a constant 0.
- Synchronous counting:
  - All flip-flops share clk.
  - T inputs are pure combinational functions of the current q[2:0].
  - No ripple clocking.
- Next-state sequence: 0→1, 1→2, 2→3, 3→4, 4→5, 5→0.
- Illegal-state recovery: internal states 6 and 7 (e.g. after an upset) go to 0 on the next rising edge. The T equations are chosen so this holds.
- The counter is always enabled. It advances on every rising edge while rst=1.
- Binary encoding: q is unsigned binary of the count value.

## Timing
- Reset assertion (rst 1→0):
  - q goes to 0 immediately, with no clock needed.
  - q holds 0 for as long as rst=0, regardless of clk.
- Reset release (rst 0→1):
  - The first rising edge after release moves q from 0 to 1.
  - Release must meet flop recovery/removal timing.
- Reset asserted mid-count, e.g. at q=3: q becomes 0 asynchronously. On release, counting restarts at 0→1.
- Latency: q reflects the new count one clk-to-q delay after each rising edge.
- Period: the count sequence repeats every 6 rising edges.
- q is glitch-free at the register outputs, since all bits are registered in the same flop stage.

## Configuration
- MOD6_TC_OUT_EN defined:
  - Adds output tc = 1 combinationally when q==5, else 0.
  - tc is 0 during reset.
  - tc pulses high for exactly one clk period out of every 6.
- MOD6_TC_OUT_EN undefined: the tc port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package (mod6_pkg) holds these constants:
  - MOD6_MODULUS = 6
  - MOD6_MAX = 5
  - MOD6_Q_W = 4
  - MOD6_STATE_W = 3
- Sub-module t_ff:
  - Ports: clk, rst (async active-low), t, q.
  - Toggles on a rising edge when t=1, holds when t=0.
  - Clears to 0 on reset.
  - Instantiated three times.
- Top level contains only the T-input combinational logic, the three t_ff instances, the q[3] tie-off, and the optional tc decode.

## Test plan
- Reset hold: drive rst=0 for 2 clk periods → q=0 throughout, and tc=0 when enabled.
- Free-run: release rst, run 20 rising edges → q = 1,2,3,4,5,0,1,… with no skipped or repeated value.
- Wrap and tc: at q=5, one edge later → q=0. With MOD6_TC_OUT_EN, tc=1 only while q=5.
- Async reset mid-count: at q=3, drop rst between clock edges → q=0 before the next edge. On release, the next edge gives q=1.
- Illegal recovery: force internal state to 6, and separately to 7, then release the force → q=0 after one rising edge, then normal sequence.
- Invariant: q[3]=0 and q≤5 on every cycle of the whole run.
